fnd_digit_scanner: RTL and testbench
====================================

// Module: fnd_digit_scanner
// PURPOSE
//  Parametrised, time-multiplexed digit-select scanner for the FND display path. It generalises the
//  fixed 2-to-4 active-low digit decoder into a free-running scan engine with these features:
//  - configurable digit count
//  - prescaled slot timing
//  - anti-ghosting blank time at the start of each slot
//  - per-digit mask
//  - selectable output polarity
//  It drives the FND common pins and tells the segment mux which digit to present.
// PARAMETERS
//  NUM_DIGITS  4       number of digits scanned; legal range 2..16
//  SCAN_DIV    100000  clk cycles per digit slot; must be >= 2
//  BLANK_CYC   1000    cycles at the start of each slot with all selects inactive; 0 <= BLANK_CYC < SCAN_DIV
//  ACTIVE_LOW  1       1: an active select bit is 0 and inactive is all-1s; 0: active-high
// PORTS
//  clk           in   1                         system clock, rising edge
//  reset         in   1                         synchronous, active-high
//  i_en          in   1                         scan enable
//  i_digit_mask  in   NUM_DIGITS                1 = digit displayed, 0 = digit kept dark
//  o_digit_sel   out  NUM_DIGITS                one-hot digit select (polarity set by ACTIVE_LOW)
//  o_digit_idx   out  IDX_W=$clog2(NUM_DIGITS)  index of the current slot, for the segment data mux
//  o_blank       out  1                         1 whenever all selects are inactive
//  o_slot_tick   out  1                         1-cycle pulse on the first cycle of each slot
// BEHAVIOUR
//  State registers
//  - Slot counter cnt, range 0..SCAN_DIV-1, width $clog2(SCAN_DIV).
//  - Digit index idx, range 0..NUM_DIGITS-1.
//  - Latched mask m_q.
//  Reset (synchronous, takes priority over everything)
//  - cnt=0, idx=0, m_q=0.
//  - o_digit_sel inactive (all-1s if ACTIVE_LOW=1, else 0), o_blank=1, o_slot_tick=0, o_digit_idx=0.
//  Advance (i_en=1)
//  - cnt increments by 1 each cycle.
//  - When cnt==SCAN_DIV-1: next cnt=0, and idx increments, wrapping from NUM_DIGITS-1 to 0.
//    Explicit wrap compare is required; NUM_DIGITS need not be a power of 2.
//  - Mask is sampled only at slot start: m_q <= i_digit_mask on the roll-over edge, and on the first
//    enabled edge after reset. A mask change mid-slot takes effect from the next slot.
//  Hold (i_en=0)
//  - cnt, idx and m_q hold their values.
//  - Selects are driven inactive from the next edge; o_blank=1; o_slot_tick=0.
//  - When i_en returns to 1, the scan resumes from the held cnt/idx with no restart.
//  Per-slot phase machine (derived from cnt)
//  - BLANK phase (cnt < BLANK_CYC): selects inactive, o_blank=1.
//  - DRIVE phase (cnt >= BLANK_CYC): select bit idx is active iff m_q[idx]=1; otherwise all inactive.
//  - o_blank = 1 whenever no bit is active, including masked slots.
//  - With BLANK_CYC=0 there is no BLANK phase.
//  Output timing
//  - All outputs are registered and computed from next-state values, so they align with the cnt/idx
//    values of the same cycle. There is no extra pipeline lag.
//  - o_digit_idx equals idx at all times, including BLANK phase and masked slots.
//  - o_slot_tick=1 exactly in the cycles where cnt==0 after a roll-over. It is not asserted in the
//    first cycle after reset.
//  Masked slots consume full slot time, so per-digit duty cycle and brightness stay uniform.
//  Duty per digit = (SCAN_DIV-BLANK_CYC) / (SCAN_DIV*NUM_DIGITS).
//  Glitch freedom: never more than one select bit active; no cycle has two digits active across a
//  slot boundary.
// TESTING (bench defaults: NUM_DIGITS=4, SCAN_DIV=8, BLANK_CYC=2, ACTIVE_LOW=1)
//  1. reset, release, i_en=1, mask=4'hF -> cycles 0-1: sel=1111, blank=1; cycles 2-7: sel=1110, idx=0;
//     cycle 8: tick=1, idx=1, sel=1111; cycle 10: sel=1101.
//  2. Run 40 cycles -> DRIVE sel sequence 1110,1101,1011,0111,1110; idx wraps 3->0 at cycle 32;
//     tick at 8,16,24,32.
//  3. mask=4'b1011; flip mask[3] to 0 at cnt=4 of slot 1 -> slot 2: sel=1111 and blank=1 for all
//     8 cycles, idx=2 held; slot-3 timing unchanged; the mask[3] flip first shows in slot 3.
//  4. i_en=0 at idx=1, cnt=5 for 6 cycles -> sel=1111, blank=1, cnt/idx frozen, no tick;
//     i_en=1 -> resumes at cnt=5 with sel=1101, roll-over 3 cycles later.
//  5. reset pulse at idx=3, cnt=4 -> next cycle: idx=0, cnt=0, sel=1111, blank=1, tick=0;
//     normal scan restarts.
//  6. NUM_DIGITS=8, SCAN_DIV=4, BLANK_CYC=0, ACTIVE_LOW=0 -> sel 8'h01,02,04,...,80,01 each for 4 cycles;
//     blank never asserted; tick every 4 cycles; idx 0..7 then wraps.

Source files
------------

// File: rtl/fnd_digit_scanner.sv
// fnd_digit_scanner: free-running, time-multiplexed digit-select scanner for the FND
// common pins. It steps through NUM_DIGITS slots of SCAN_DIV cycles each. Every slot
// opens with BLANK_CYC dark cycles so that the previous digit has fully released
// before the next one is driven. A per-digit mask, latched at slot start, can keep
// individual digits dark without changing slot timing.
// All outputs are registered from next-state values, so they line up with cnt/idx
// in the same cycle and have no pipeline lag.
module fnd_digit_scanner #(
    parameter int NUM_DIGITS = 4,
    parameter int SCAN_DIV   = 100000,
    parameter int BLANK_CYC  = 1000,
    parameter bit ACTIVE_LOW = 1'b1,
    localparam int IDX_W     = $clog2(NUM_DIGITS),
    localparam int CNT_W     = $clog2(SCAN_DIV)
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  i_en,
    input  logic [NUM_DIGITS-1:0] i_digit_mask,
    output logic [NUM_DIGITS-1:0] o_digit_sel,
    output logic [IDX_W-1:0]      o_digit_idx,
    output logic                  o_blank,
    output logic                  o_slot_tick
);

    localparam logic [CNT_W-1:0]      CNT_MAX = CNT_W'(SCAN_DIV - 1);
    localparam logic [IDX_W-1:0]      IDX_MAX = IDX_W'(NUM_DIGITS - 1);
    localparam logic [NUM_DIGITS-1:0] SEL_OFF = {NUM_DIGITS{ACTIVE_LOW}};

    // Slot phase derived from the counter; OFF covers the disabled case.
    typedef enum logic [1:0] {
        PH_OFF   = 2'd0,
        PH_BLANK = 2'd1,
        PH_DRIVE = 2'd2
    } phase_t;

    // Scan state
    logic [CNT_W-1:0]      cnt, cnt_n;
    logic [IDX_W-1:0]      idx, idx_n;
    logic [NUM_DIGITS-1:0] m_q, m_n;
    logic                  first_q, first_n;  // mask not yet sampled since reset

    // Next-state helpers
    logic   roll;
    logic   in_blank_n;
    phase_t phase_n;

    // Output next values
    logic                  lit_n;
    logic [NUM_DIGITS-1:0] sel_n;
    logic                  blank_n;
    logic                  tick_n;

    logic [NUM_DIGITS-1:0] sel_q;
    logic                  blank_q;
    logic                  tick_q;

    // State register: counter, digit index, latched mask and the post-reset arm flag
    always_ff @(posedge clk) begin
        if (reset) begin
            cnt     <= '0;
            idx     <= '0;
            m_q     <= '0;
            first_q <= 1'b1;
        end else begin
            cnt     <= cnt_n;
            idx     <= idx_n;
            m_q     <= m_n;
            first_q <= first_n;
        end
    end

    // Next-state logic: advance while enabled, hold everything otherwise
    always_comb begin
        roll    = i_en && (cnt == CNT_MAX);
        cnt_n   = cnt;
        idx_n   = idx;
        m_n     = m_q;
        first_n = first_q && !i_en;
        if (i_en) begin
            if (roll) begin
                cnt_n = '0;
                // Explicit wrap compare: NUM_DIGITS need not be a power of two.
                idx_n = (idx == IDX_MAX) ? '0 : idx + IDX_W'(1);
            end else begin
                cnt_n = cnt + CNT_W'(1);
            end
            // Mask is only sampled at slot start, so a mid-slot change waits a slot.
            if (roll || first_q)
                m_n = i_digit_mask;
        end
    end

    // Blank-window test on the next counter value; absent when BLANK_CYC is zero
    generate
        if (BLANK_CYC == 0) begin : g_no_blank
            assign in_blank_n = 1'b0;
        end else begin : g_blank
            localparam logic [CNT_W-1:0] BLANK_LIM = CNT_W'(BLANK_CYC);
            assign in_blank_n = (cnt_n < BLANK_LIM);
        end
    endgenerate

    // Phase decode for the coming cycle
    always_comb begin
        phase_n = PH_OFF;
        if (i_en)
            phase_n = in_blank_n ? PH_BLANK : PH_DRIVE;
    end

    // Output decode from next-state values: at most one select bit ever active
    always_comb begin
        lit_n   = (phase_n == PH_DRIVE) && m_n[idx_n];
        sel_n   = SEL_OFF;
        if (lit_n)
            sel_n = SEL_OFF ^ (NUM_DIGITS'(1) << idx_n);
        blank_n = !lit_n;
        tick_n  = roll;
    end

    // Output register: keeps the pin drivers glitch-free
    always_ff @(posedge clk) begin
        if (reset) begin
            sel_q   <= SEL_OFF;
            blank_q <= 1'b1;
            tick_q  <= 1'b0;
        end else begin
            sel_q   <= sel_n;
            blank_q <= blank_n;
            tick_q  <= tick_n;
        end
    end

    assign o_digit_sel = sel_q;
    assign o_digit_idx = idx;
    assign o_blank     = blank_q;
    assign o_slot_tick = tick_q;

endmodule

// File: tb/tb_fnd_digit_scanner.sv
// Directed, table-driven bench for fnd_digit_scanner. Instance A uses the small
// default configuration (4 digits, 8-cycle slots, 2 blank cycles, active-low);
// instance B uses 8 digits, 4-cycle slots, no blank and active-high selects.
module tb_fnd_digit_scanner;

    logic       clk;
    logic       rst_a, en_a;
    logic [3:0] mask_a, sel_a;
    logic [1:0] idx_a;
    logic       blank_a, tick_a;

    logic       rst_b, en_b;
    logic [7:0] mask_b, sel_b;
    logic [2:0] idx_b;
    logic       blank_b, tick_b;

    int n_checks = 0;
    int n_fail   = 0;

    fnd_digit_scanner #(.NUM_DIGITS(4), .SCAN_DIV(8), .BLANK_CYC(2), .ACTIVE_LOW(1'b1)) dut_a (
        .clk(clk), .reset(rst_a), .i_en(en_a), .i_digit_mask(mask_a),
        .o_digit_sel(sel_a), .o_digit_idx(idx_a), .o_blank(blank_a), .o_slot_tick(tick_a)
    );

    fnd_digit_scanner #(.NUM_DIGITS(8), .SCAN_DIV(4), .BLANK_CYC(0), .ACTIVE_LOW(1'b0)) dut_b (
        .clk(clk), .reset(rst_b), .i_en(en_b), .i_digit_mask(mask_b),
        .o_digit_sel(sel_b), .o_digit_idx(idx_b), .o_blank(blank_b), .o_slot_tick(tick_b)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // One vector: inputs for the coming edge, outputs expected just after it
    typedef struct packed {
        logic       rst;
        logic       en;
        logic [7:0] mask;
        logic [7:0] sel;
        logic [2:0] idx;
        logic       blank;
        logic       tick;
    } vec_t;

    vec_t vq[$];

    function automatic vec_t mk(logic rst, logic en, logic [7:0] mask, logic [7:0] sel,
                                logic [2:0] idx, logic blank, logic tick);
        vec_t v;
        v.rst = rst; v.en = en; v.mask = mask; v.sel = sel;
        v.idx = idx; v.blank = blank; v.tick = tick;
        return v;
    endfunction

    // Instance A, k enabled edges after reset: cnt=k%8, idx=(k/8)%4, lit when cnt>=2 and digit unmasked
    function automatic vec_t scan_a(int k, logic [3:0] mask_in, logic [3:0] mlat);
        int c = k % 8;
        int d = (k / 8) % 4;
        logic lit = (c >= 2) && mlat[d];
        logic [3:0] s = 4'hF;
        if (lit) s[d] = 1'b0;
        return mk(1'b0, 1'b1, {4'h0, mask_in}, {4'h0, s}, 3'(d), !lit, (c == 0));
    endfunction

    // Instance B, k enabled edges after reset: cnt=k%4, idx=(k/4)%8, always lit
    function automatic vec_t scan_b(int k);
        int c = k % 4;
        int d = (k / 4) % 8;
        logic [7:0] s = 8'h00;
        s[d] = 1'b1;
        return mk(1'b0, 1'b1, 8'hFF, s, 3'(d), 1'b0, (c == 0));
    endfunction

    task automatic chk(input string name, input int i, input logic [7:0] act, input logic [7:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s vec %0d: got %h expected %h", name, i, act, exp);
        end
    endtask

    task automatic run(input bit use_b, input string tag);
        for (int i = 0; i < vq.size(); i++) begin
            if (use_b) begin
                rst_b = vq[i].rst; en_b = vq[i].en; mask_b = vq[i].mask;
            end else begin
                rst_a = vq[i].rst; en_a = vq[i].en; mask_a = vq[i].mask[3:0];
            end
            @(posedge clk);
            #1;
            if (use_b) begin
                chk({tag, ".sel"},   i, sel_b,                 vq[i].sel);
                chk({tag, ".idx"},   i, {5'd0, idx_b},         {5'd0, vq[i].idx});
                chk({tag, ".blank"}, i, {7'd0, blank_b},       {7'd0, vq[i].blank});
                chk({tag, ".tick"},  i, {7'd0, tick_b},        {7'd0, vq[i].tick});
            end else begin
                chk({tag, ".sel"},   i, {4'h0, sel_a},         vq[i].sel);
                chk({tag, ".idx"},   i, {6'd0, idx_a},         {5'd0, vq[i].idx});
                chk({tag, ".blank"}, i, {7'd0, blank_a},       {7'd0, vq[i].blank});
                chk({tag, ".tick"},  i, {7'd0, tick_a},        {7'd0, vq[i].tick});
            end
        end
        vq.delete();
    endtask

    task automatic add_reset_a();
        vq.push_back(mk(1'b1, 1'b0, 8'h0, 8'h0F, 3'd0, 1'b1, 1'b0));
    endtask

    initial begin
        rst_a = 1'b1; en_a = 1'b0; mask_a = 4'h0;
        rst_b = 1'b1; en_b = 1'b0; mask_b = 8'h00;
        @(posedge clk);
        #1;

        // Reset state, idle cycle, first slots (hand values), then 40-cycle scan with wrap
        add_reset_a();
        add_reset_a();
        vq.push_back(mk(1'b0, 1'b0, 8'h0F, 8'h0F, 3'd0, 1'b1, 1'b0));
        vq.push_back(mk(1'b0, 1'b1, 8'h0F, 8'h0F, 3'd0, 1'b1, 1'b0)); // cnt 1
        for (int k = 2; k <= 7; k++)
            vq.push_back(mk(1'b0, 1'b1, 8'h0F, 8'h0E, 3'd0, 1'b0, 1'b0));
        vq.push_back(mk(1'b0, 1'b1, 8'h0F, 8'h0F, 3'd1, 1'b1, 1'b1)); // cnt 0, slot 1
        vq.push_back(mk(1'b0, 1'b1, 8'h0F, 8'h0F, 3'd1, 1'b1, 1'b0)); // cnt 1
        vq.push_back(mk(1'b0, 1'b1, 8'h0F, 8'h0D, 3'd1, 1'b0, 1'b0)); // cnt 2
        for (int k = 11; k <= 40; k++)
            vq.push_back(scan_a(k, 4'hF, 4'hF));
        run(1'b0, "scan");

        // Mask 1011; bits 3 and 1 cleared at cnt 4 of slot 1: slot 1 stays lit,
        // slots 2 and 3 dark, slot 0 lit, slot 1 now dark
        add_reset_a();
        for (int k = 1; k <= 42; k++)
            vq.push_back(scan_a(k, (k < 13) ? 4'b1011 : 4'b0001,
                                   (k < 16) ? 4'b1011 : 4'b0001));
        run(1'b0, "mask");

        // Hold at idx 1 / cnt 5 for 6 cycles, then resume without restart
        add_reset_a();
        for (int k = 1; k <= 13; k++)
            vq.push_back(scan_a(k, 4'hF, 4'hF));
        for (int k = 0; k < 6; k++)
            vq.push_back(mk(1'b0, 1'b0, 8'h0F, 8'h0F, 3'd1, 1'b1, 1'b0));
        for (int k = 14; k <= 18; k++)
            vq.push_back(scan_a(k, 4'hF, 4'hF));
        run(1'b0, "hold");

        // Reset pulse mid-slot at idx 3 / cnt 4, then normal restart
        add_reset_a();
        for (int k = 1; k <= 28; k++)
            vq.push_back(scan_a(k, 4'hF, 4'hF));
        vq.push_back(mk(1'b1, 1'b1, 8'h0F, 8'h0F, 3'd0, 1'b1, 1'b0));
        for (int k = 1; k <= 10; k++)
            vq.push_back(scan_a(k, 4'hF, 4'hF));
        run(1'b0, "rstpulse");

        // Eight digits, active-high, no blank window
        vq.push_back(mk(1'b1, 1'b0, 8'h00, 8'h00, 3'd0, 1'b1, 1'b0));
        for (int k = 1; k <= 36; k++)
            vq.push_back(scan_b(k));
        run(1'b1, "wide");

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
